biquad8_coeff_loader: RTL

//  Wishbone initiator that programs one biquad8 filter's coefficient space from a local table.
//  On start_i it walks NENTRY table entries, issuing one WB write per entry.
//  It then issues a final write to the UPDATE register (0x00, data bit0=1) so all staged coefficients commit.

---
 rtl/biquad8_pkg.sv | 48 ++++
 rtl/wb_single_write.sv | 63 ++++++
 rtl/biquad8_coeff_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/biquad8_pkg.sv
// Shared biquad8 register map, loader state encoding, bus payload types and payload helpers.
package biquad8_pkg;

    localparam int unsigned BQ_COEFF_BITS = 18;
    localparam int unsigned BQ_SEL_BITS   = 5;
    localparam int unsigned BQ_TBL_BITS   = BQ_SEL_BITS + BQ_COEFF_BITS;
    localparam int unsigned WB_ADR_BITS   = 7;
    localparam int unsigned WB_DAT_BITS   = 32;
    localparam int unsigned WB_SEL_BITS   = 4;

    localparam logic [WB_ADR_BITS-1:0] BQ_ADR_UPDATE  = 7'h00;
    localparam logic [WB_ADR_BITS-1:0] BQ_ADR_FIR     = 7'h04;
    localparam logic [WB_ADR_BITS-1:0] BQ_ADR_IIR     = 7'h08;
    localparam logic [WB_ADR_BITS-1:0] BQ_ADR_POLEFIR = 7'h10;
    localparam logic [WB_ADR_BITS-1:0] BQ_ADR_MASK    = 7'h70;

    typedef enum logic [2:0] {
        LS_IDLE, LS_FETCH, LS_LATCH, LS_WRITE, LS_GAP, LS_UPD, LS_UPDGAP, LS_DONE
    } loader_state_t;

    typedef struct packed {
        logic [BQ_SEL_BITS-1:0]   reg_sel;
        logic [BQ_COEFF_BITS-1:0] coeff;
    } bq_tbl_entry_t;

    typedef struct packed {
        logic [WB_ADR_BITS-1:0] adr;
        logic [WB_DAT_BITS-1:0] dat;
        logic [WB_SEL_BITS-1:0] sel;
    } wb_wr_t;

    function automatic wb_wr_t bq_coeff_write(input bq_tbl_entry_t e);
        wb_wr_t w;
        w.adr = {e.reg_sel, 2'b00};
        w.dat = WB_DAT_BITS'(e.coeff);
        w.sel = 4'hF;
        return w;
    endfunction

    function automatic wb_wr_t bq_update_write();
        wb_wr_t w;
        w.adr = BQ_ADR_UPDATE;
        w.dat = 32'h1;
        w.sel = 4'h1;
        return w;
    endfunction

endpackage

// File: rtl/wb_single_write.sv
// One Wishbone write: holds the payload with cyc/stb up until ack, err/rty or wait timeout.
module wb_single_write
    import biquad8_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  wb_wr_t                 i_req,
    input  logic                   i_ack,
    input  logic                   i_err,
    input  logic                   i_rty,
    output logic                   o_cyc,
    output logic                   o_stb,
    output logic                   o_we,
    output logic [WB_ADR_BITS-1:0] o_adr,
    output logic [WB_DAT_BITS-1:0] o_dat,
    output logic [WB_SEL_BITS-1:0] o_sel,
    output logic                   o_ok_c,
    output logic                   o_fail_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic             r_stb;
    logic [CNT_W-1:0] r_wait;
    wb_wr_t           r_req;
    logic             w_bad;
    logic             w_timeout;

    // Error beats ack; the timeout fires on the last allowed wait cycle without ack.
    assign w_bad     = r_stb & (i_err | i_rty);
    assign w_timeout = r_stb & ~i_ack & ~w_bad & (r_wait == CNT_W'(TIMEOUT - 1));
    assign o_ok_c    = r_stb & i_ack & ~w_bad;
    assign o_fail_c  = w_bad | w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stb  <= 1'b0;
            r_wait <= '0;
            r_req  <= '0;
        end else if (i_start) begin
            r_stb  <= 1'b1;
            r_wait <= '0;
            r_req  <= i_req;
        end else if (r_stb) begin
            if (o_ok_c || o_fail_c) begin
                r_stb <= 1'b0;
            end else begin
                r_wait <= r_wait + CNT_W'(1);
            end
        end
    end

    assign o_cyc = r_stb;
    assign o_stb = r_stb;
    assign o_we  = r_stb;
    assign o_adr = r_req.adr;
    assign o_dat = r_req.dat;
    assign o_sel = r_req.sel;

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Walks a coefficient table, writes each entry to a biquad8 over Wishbone, then commits via UPDATE.
module biquad8_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int unsigned NENTRY  = 16,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TBLBITS = (NENTRY > 1) ? $clog2(NENTRY) : 1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   start_i,
    output logic [TBLBITS-1:0]     tbl_adr_o,
    input  logic [BQ_TBL_BITS-1:0] tbl_dat_i,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [WB_ADR_BITS-1:0] wb_adr_o,
    output logic [WB_DAT_BITS-1:0] wb_dat_o,
    output logic [WB_SEL_BITS-1:0] wb_sel_o,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam logic [2:0] S_IDLE   = LS_IDLE;
    localparam logic [2:0] S_FETCH  = LS_FETCH;
    localparam logic [2:0] S_LATCH  = LS_LATCH;
    localparam logic [2:0] S_WRITE  = LS_WRITE;
    localparam logic [2:0] S_GAP    = LS_GAP;
    localparam logic [2:0] S_UPD    = LS_UPD;
    localparam logic [2:0] S_UPDGAP = LS_UPDGAP;
    localparam logic [2:0] S_DONE   = LS_DONE;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [TBLBITS-1:0] r_idx;
    logic [TBLBITS-1:0] w_idx_nxt;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_start;
    wb_wr_t             w_req;
    bq_tbl_entry_t      w_entry;
    logic               w_ok;
    logic               w_fail;

    assign w_entry = bq_tbl_entry_t'(tbl_dat_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        end
    end

    // A reg_sel of zero marks the end of the table: skip straight to the commit write.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err;
        w_start     = 1'b0;
        w_req       = bq_update_write();
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_FETCH: w_state_nxt = S_LATCH;
            S_LATCH: begin
                w_start = 1'b1;
                if (w_entry.reg_sel == '0) begin
                    w_state_nxt = S_UPD;
                end else begin
                    w_state_nxt = S_WRITE;
                    w_req       = bq_coeff_write(w_entry);
                end
            end
            S_WRITE: begin
                if (w_fail) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else if (w_ok) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_idx < TBLBITS'(NENTRY - 1)) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = r_idx + TBLBITS'(1);
                end else begin
                    w_state_nxt = S_UPD;
                    w_start     = 1'b1;
                end
            end
            S_UPD: begin
                if (w_fail) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else if (w_ok) begin
                    w_state_nxt = S_UPDGAP;
                end
            end
            S_UPDGAP: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    wb_single_write #(.TIMEOUT(TIMEOUT)) u_wr (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .i_start  (w_start),
        .i_req    (w_req),
        .i_ack    (wb_ack_i),
        .i_err    (wb_err_i),
        .i_rty    (wb_rty_i),
        .o_cyc    (wb_cyc_o),
        .o_stb    (wb_stb_o),
        .o_we     (wb_we_o),
        .o_adr    (wb_adr_o),
        .o_dat    (wb_dat_o),
        .o_sel    (wb_sel_o),
        .o_ok_c   (w_ok),
        .o_fail_c (w_fail)
    );

    assign tbl_adr_o = r_idx;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;

endmodule
